// File: rtl/display_fifo_if.sv
// display_fifo_if
// Bus-side signals of the display output unit: the write strobe, channel select
// and data coming from bus_out, plus the status flags and channel latches.
// Optional status readback (out_en / rd_data) exists only when the macro
// DSP_READBACK_EN is defined.
interface display_fifo_if #(
   parameter int WIDTH    = 16,
   parameter int CHANNELS = 2
);
   localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   logic                      in_en;
   logic [CH_W-1:0]           ch_sel;
   logic [WIDTH-1:0]          in;
   logic                      full;
   logic                      empty;
   logic                      busy;
   logic [CHANNELS*WIDTH-1:0] out;

`ifdef DSP_READBACK_EN
   logic                      out_en;
   logic [WIDTH-1:0]          rd_data;

   modport master (
      output in_en, ch_sel, in, out_en,
      input  full, empty, busy, out, rd_data
   );

   modport slave (
      input  in_en, ch_sel, in, out_en,
      output full, empty, busy, out, rd_data
   );
`else
   modport master (
      output in_en, ch_sel, in,
      input  full, empty, busy, out
   );

   modport slave (
      input  in_en, ch_sel, in,
      output full, empty, busy, out
   );
`endif

endinterface

// File: rtl/display_fifo.sv
// display_fifo
// Bus-attached output unit with CHANNELS output latches. A DEPTH-entry write
// FIFO decouples the core from the latches; a three-state drain FSM moves one
// word at a time into its target channel and holds it for HOLD_CYCLES cycles
// before draining the next one, so LEDs/pins stay readable.
// Optional feature: define DSP_READBACK_EN to get the sticky overflow flag
// and a combinational status word on rd_data (gated by out_en).
module display_fifo #(
   parameter int WIDTH       = 16,
   parameter int DEPTH       = 4,
   parameter int CHANNELS    = 2,
   parameter int HOLD_CYCLES = 4
) (
   input  logic            clk,
   input  logic            rst,
   display_fifo_if.slave   bus_if
);

   // Address bits of the storage array; pointers carry one extra wrap bit so
   // that full and empty are distinguishable.
   localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int PW   = AW + 1;
   localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int HW   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int EW   = CH_W + WIDTH;

   localparam logic [PW-1:0] DEPTH_P   = PW'(DEPTH);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   // FIFO storage: each entry is {channel, data}
   logic [EW-1:0]             mem [DEPTH];

   logic [PW-1:0]             wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]             rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]             count_d;
   logic                      full_q, full_d;
   logic                      empty_q, empty_d;

   state_t                    state_q, state_d;
   logic [HW-1:0]             hold_q, hold_d;

   logic                      push;
   logic                      pop;
   logic [EW-1:0]             head;
   logic [CH_W-1:0]           head_ch;
   logic [WIDTH-1:0]          head_data;
   logic                      busy_w;
   logic [CHANNELS*WIDTH-1:0] out_flat;

   // A push is accepted only against the registered full flag; a pop frees a
   // slot on the same edge but cannot make room for a push in that cycle.
   assign push = bus_if.in_en && !full_q;
   assign pop  = (state_q == S_LOAD);

   // The head entry is read combinationally so the LOAD cycle can latch it
   assign head      = mem[rd_ptr_q[AW-1:0]];
   assign head_ch   = head[EW-1:WIDTH];
   assign head_data = head[WIDTH-1:0];

   // Storage write; contents need no reset because the pointers define validity
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q[AW-1:0]] <= {bus_if.ch_sel, bus_if.in};
      end
   end

   // Next pointer values and the flags derived from the resulting occupancy
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = wr_ptr_d - rd_ptr_d;
      full_d  = (count_d == DEPTH_P);
      empty_d = (count_d == '0);
   end

   // Pointer and flag registers; flags move on the same edge as push/pop
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   // Drain FSM next-state: IDLE waits for data, LOAD pops one word, HOLD
   // counts down HOLD_CYCLES cycles before the next drain decision.
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      unique case (state_q)
         S_IDLE: begin
            if (!empty_q) begin
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            hold_d  = HOLD_LAST;
            state_d = S_HOLD;
         end
         S_HOLD: begin
            if (hold_q == '0) begin
               state_d = empty_q ? S_IDLE : S_LOAD;
            end else begin
               hold_d = hold_q - HW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            hold_d  = '0;
         end
      endcase
   end

   // Drain FSM state and hold counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
      end
   end

   assign busy_w = (state_q != S_IDLE);

   // One latch per output channel; unaddressed channels keep their value
   generate
      for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
         logic [WIDTH-1:0] chan_q;

         // Capture the head word when the LOAD targets this channel
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               chan_q <= '0;
            end else if (pop && (head_ch == CH_W'(gi))) begin
               chan_q <= head_data;
            end
         end

         assign out_flat[gi*WIDTH +: WIDTH] = chan_q;
      end
   endgenerate

   assign bus_if.out   = out_flat;
   assign bus_if.full  = full_q;
   assign bus_if.empty = empty_q;
   assign bus_if.busy  = busy_w;

`ifdef DSP_READBACK_EN
   logic          overflow_q;
   logic [PW-1:0] count_q;

   assign count_q = wr_ptr_q - rd_ptr_q;

   // Sticky overflow: any strobe while full is remembered until reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow_q <= 1'b0;
      end else if (bus_if.in_en && full_q) begin
         overflow_q <= 1'b1;
      end
   end

   // Status word for the bus mux; zero whenever it is not selected
   always_comb begin
      bus_if.rd_data = '0;
      if (bus_if.out_en) begin
         bus_if.rd_data = {overflow_q, full_q, empty_q, busy_w, (WIDTH-4)'(count_q)};
      end
   end
`endif

endmodule
